// File: rtl/sap_pkg.sv
// Shared SAP control-path types: stack operation decode, stack occupancy states
// and the default program-counter width.
package sap_pkg;

    localparam int SAP_AW = 8;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } stack_op_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PART,
        ST_FULL
    } stack_state_t;

    function automatic stack_op_t decode_op(input logic call, input logic ret);
        stack_op_t op;
        case ({call, ret})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x AW return-address storage: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module stack_regfile #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [AW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [AW-1:0]            rdata_o
);

    logic [AW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Return-address stack for nested JMS/BRB subroutine calls.
// Define CALL_STACK_WRAP_EN to make a push when full overwrite the oldest entry.
module call_stack
    import sap_pkg::*;
#(
    parameter int AW      = SAP_AW,
    parameter int DEPTH   = 4,
    parameter int RET_INC = 0
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              pc_in,
    output logic [AW-1:0]              ret_addr,
    output logic                       ret_addr_vld,
    output logic [AW-1:0]              ret_addr_q,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0] wp_q, wp_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] raq_q, raq_d;
    stack_state_t  state_q, state_d;

    stack_op_t     op;
    logic          is_full, is_empty;
    logic [PW-1:0] top_idx;
    logic          we;
    logic [PW-1:0] waddr;
    logic [AW-1:0] wdata;
    logic [AW-1:0] rd_data;

    assign op       = decode_op(call, ret);
    assign is_full  = (state_q == ST_FULL);
    assign is_empty = (state_q == ST_EMPTY);
    assign top_idx  = wp_q - PTR_ONE;

    stack_regfile #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we_i    (we & clr_n),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (top_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        wp_d    = wp_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        vld_d   = 1'b0;
        raq_d   = raq_q;
        we      = 1'b0;
        waddr   = wp_q;
        wdata   = pc_in + AW'(RET_INC);
        case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    wp_d    = wp_q + PTR_ONE;
                    level_d = level_q + LVL_ONE;
                end else begin
                    ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    // When full, wp already points at the oldest entry.
                    we    = 1'b1;
                    wp_d  = wp_q + PTR_ONE;
`endif
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    raq_d   = rd_data;
                    vld_d   = 1'b1;
                    wp_d    = top_idx;
                    level_d = level_q - LVL_ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_SWAP: begin
                we = 1'b1;
                if (!is_empty) begin
                    raq_d = rd_data;
                    vld_d = 1'b1;
                    waddr = top_idx;
                end else begin
                    unf_d   = 1'b1;
                    wp_d    = wp_q + PTR_ONE;
                    level_d = level_q + LVL_ONE;
                end
            end
            default: ;
        endcase
    end

    // Occupancy FSM tracks the post-update level so full/empty never lag it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (level_d == LVL_FULL) begin
                    state_d = ST_FULL;
                end else if (level_d != '0) begin
                    state_d = ST_PART;
                end
            end
            ST_PART: begin
                if (level_d == '0) begin
                    state_d = ST_EMPTY;
                end else if (level_d == LVL_FULL) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (level_d != LVL_FULL) begin
                    state_d = ST_PART;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            vld_q   <= 1'b0;
            raq_q   <= '0;
            state_q <= ST_EMPTY;
        end else begin
            wp_q    <= wp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            vld_q   <= vld_d;
            raq_q   <= raq_d;
            state_q <= state_d;
        end
    end

    assign ret_addr     = is_empty ? '0 : rd_data;
    assign ret_addr_vld = vld_q;
    assign ret_addr_q   = raq_q;
    assign level        = level_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign ovf          = ovf_q;
    assign unf          = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: queue-based LIFO reference model, directed
// scenarios followed by random call/ret/reset traffic.
module tb_call_stack;

    localparam int AW      = 8;
    localparam int DEPTH   = 4;
    localparam int RET_INC = 1;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic [AW-1:0] ret_addr;
    logic          ret_addr_vld;
    logic [AW-1:0] ret_addr_q;
    logic [LW-1:0] level;
    logic          full, empty, ovf, unf;

    call_stack #(
        .AW      (AW),
        .DEPTH   (DEPTH),
        .RET_INC (RET_INC)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .call         (call),
        .ret          (ret),
        .pc_in        (pc_in),
        .ret_addr     (ret_addr),
        .ret_addr_vld (ret_addr_vld),
        .ret_addr_q   (ret_addr_q),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .ovf          (ovf),
        .unf          (unf)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue whose back is the top of stack.
    logic [AW-1:0] stk[$];
    logic [AW-1:0] exp_q[$];
    bit            m_ovf, m_unf, m_vld;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: every valid pulse pops one expected address from the scoreboard.
    always @(negedge clk) begin
        if (ret_addr_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got=%0h expected=no pulse at t=%0t", ret_addr_q, $time);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                $display("pop: ret_addr_q=%02h expected=%02h", ret_addr_q, e);
                chk("ret_addr_q", 32'(ret_addr_q), 32'(e));
            end
        end
    end

    task automatic step(input bit c, input bit r, input logic [AW-1:0] pc, input bit rst_n);
        logic [AW-1:0] v;
        v      = pc + AW'(RET_INC);
        clr_n  = rst_n;
        call   = c;
        ret    = r;
        pc_in  = pc;
        m_vld  = 1'b0;
        if (!rst_n) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (c && !r) begin
            if (stk.size() < DEPTH) begin
                stk.push_back(v);
            end else begin
                m_ovf = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                void'(stk.pop_front());
                stk.push_back(v);
`endif
            end
        end else if (!c && r) begin
            if (stk.size() > 0) begin
                exp_q.push_back(stk.pop_back());
                m_vld = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end else if (c && r) begin
            if (stk.size() > 0) begin
                exp_q.push_back(stk.pop_back());
                m_vld = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
            stk.push_back(v);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("level", 32'(level), 32'(stk.size()));
        chk("full", 32'(full), 32'(stk.size() == DEPTH));
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("unf", 32'(unf), 32'(m_unf));
        chk("ret_addr_vld", 32'(ret_addr_vld), 32'(m_vld));
        chk("ret_addr", 32'(ret_addr), (stk.size() == 0) ? 32'h0 : 32'(stk[$]));
        chk("pending_pops", 32'(exp_q.size()), 32'h0);
        if (!rst_n) begin
            chk("ret_addr_q_rst", 32'(ret_addr_q), 32'h0);
        end
    endtask

    initial begin
        int phase;
        // Reset state
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);

        // Nested calls return in LIFO order
        step(1, 0, 8'h10, 1);
        step(1, 0, 8'h20, 1);
        step(1, 0, 8'h30, 1);
        repeat (3) step(0, 1, 8'h00, 1);

        // Overflow: fifth push when DEPTH=4
        for (int i = 1; i <= 5; i++) step(1, 0, AW'(i), 1);
        repeat (4) step(0, 1, 8'h00, 1);

        // Underflow stays sticky across later traffic
        step(0, 1, 8'h00, 1);
        step(1, 0, 8'h66, 1);
        step(0, 1, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Swap replaces the top entry
        step(1, 0, 8'h40, 1);
        step(1, 1, 8'h55, 1);
        step(0, 1, 8'h00, 1);
        step(1, 1, 8'h77, 1);
        step(0, 0, 8'h00, 0);

        // Address wraps modulo 2^AW
        step(1, 0, 8'hFF, 1);
        step(0, 1, 8'h00, 1);

        // Reset dominates a simultaneous call
        step(1, 0, 8'h11, 1);
        step(1, 0, 8'h22, 1);
        step(1, 0, 8'h33, 0);
        step(0, 0, 8'h00, 1);

        // Random traffic with a slowly drifting push/pop bias
        for (int n = 0; n < 800; n++) begin
            int dice;
            phase = (n / 40) % 3;
            dice  = int'($urandom_range(0, 99));
            if ($urandom_range(0, 63) == 0) begin
                step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), AW'($urandom), 0);
            end else if (dice < 10) begin
                step(0, 0, AW'($urandom), 1);
            end else if (dice < 25) begin
                step(1, 1, AW'($urandom), 1);
            end else if (dice < (phase == 0 ? 75 : (phase == 1 ? 35 : 55))) begin
                step(1, 0, AW'($urandom), 1);
            end else begin
                step(0, 1, AW'($urandom), 1);
            end
        end

        step(0, 0, 8'h00, 1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Parametrised return-address stack for the SAP-family control path.
- Replaces the single-level subroutine counter and J-K select flip-flop, so nested subroutine calls (JMS/BRB) become possible.
- Sits beside the program counter: on a call it captures the next-PC value; on a return it supplies the saved address to be loaded into the PC.
- Flags full/empty and latches sticky overflow/underflow errors for the controller's halt logic.

Parameters:
- AW, 8: address width (program-counter width).
- DEPTH, 4: number of stack entries; must be a power of two, at least 2.
- RET_INC, 0: constant added (modulo 2^AW) to pc_in when pushing.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  synchronous active-low reset, sampled on posedge clk.
- call  in  1  push request (JMS execute step).
- ret  in  1  pop request (BRB execute step).
- pc_in  in  AW  current PC value to save.
- ret_addr  out  AW  top-of-stack address, valid when empty=0.
- ret_addr_vld  out  1  registered; high for one cycle after an accepted pop.
- ret_addr_q  out  AW  registered copy of the popped address; held until the next pop.
- level  out  $clog2(DEPTH)+1  number of occupied entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- ovf  out  1  sticky: a push was attempted while full.
- unf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (clr_n=0 at posedge):
  - level=0, write pointer=0, ovf=0, unf=0, ret_addr_vld=0, ret_addr_q=0.
  - Entry contents are not cleared.
  - Reset dominates any simultaneous call/ret.
- Push (call=1, ret=0, not full):
  - mem[wp] <= pc_in + RET_INC (truncated to AW).
  - wp <= wp+1 (wraps modulo DEPTH); level+1.
- Pop (ret=1, call=0, not empty):
  - ret_addr_q <= mem[wp-1]; ret_addr_vld <= 1.
  - wp <= wp-1; level-1.
  - Latency: ret_addr is combinational and valid in the same cycle; ret_addr_q/ret_addr_vld appear one cycle later.
- Swap (call=1 and ret=1, not empty):
  - Pop the current top into ret_addr_q (ret_addr_vld=1), then write pc_in+RET_INC into the same slot.
  - level and wp are unchanged; ovf is not affected.
- Swap when empty: treated as a plain push; unf <= 1.
- Full push (without the optional feature): request ignored; state unchanged; ovf <= 1.
- Empty pop: request ignored; ret_addr_vld=0; unf <= 1.
- ret_addr when empty: drives 0.
- ovf and unf clear only on reset.
- ret_addr_vld is a single-cycle pulse; back-to-back pops give back-to-back pulses.
- Internal FSM, derived from level:
  - EMPTY: push -> PART (or FULL if DEPTH==1 is ever allowed).
  - PART: push -> FULL when level becomes DEPTH; pop -> EMPTY when level becomes 0.
  - FULL: pop -> PART.
  - The FSM state must always agree with full/empty.

Optional Feature:
- CALL_STACK_WRAP_EN defined: a push when full overwrites the oldest entry (circular buffer).
  - wp advances; level stays at DEPTH; ovf is still set.
  - Subsequent pops return the newest DEPTH addresses in LIFO order.
- CALL_STACK_WRAP_EN undefined: a push when full is dropped, as described in Behaviour.

Decomposition:
- Shared package sap_pkg holds:
  - the stack_op_t enum {OP_NONE, OP_PUSH, OP_POP, OP_SWAP}, decoded from {call, ret};
  - the default AW constant;
  - the stack_state_t enum {ST_EMPTY, ST_PART, ST_FULL}.
- One sub-module, stack_regfile: DEPTH x AW register array with a single synchronous write port and an asynchronous read port.
- Pointer, level, flags and FSM live in call_stack.

Test Plan:
1. Reset, then push pc_in=0x10, 0x20, 0x30 (RET_INC=0) -> level=3, ret_addr=0x30; three pops -> ret_addr_q sequence 0x30, 0x20, 0x10 with ret_addr_vld each cycle; empty=1.
2. DEPTH=4: push 5 values 0x01..0x05 -> full=1, ovf=1, level=4; pops return 0x04..0x01 (wrap-off), or 0x05..0x02 with CALL_STACK_WRAP_EN.
3. Pop while empty -> unf=1, ret_addr_vld=0, level=0; unf stays 1 until clr_n=0.
4. Push 0x40, then call=ret=1 with pc_in=0x55 -> ret_addr_q=0x40, ret_addr=0x55, level=1.
5. RET_INC=1, AW=8: push pc_in=0xFF -> popped value 0x00.
6. Two pushes, then clr_n=0 together with call=1 -> level=0, empty=1, ovf=unf=0; push is not performed.
